// File: rtl/square_freq_meter.sv
// Square-wave frequency meter: hysteresis slicer, then a gated rising-edge counter and span timer.
// Build option SQUARE_FREQ_METER_MINMAX_EN adds levelMax/levelMin of the level seen during the gate.
module square_freq_meter #(
    parameter int unsigned GATE_CYCLES    = 1000000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter logic [7:0]  HI_THRESH      = 8'd160,
    parameter logic [7:0]  LO_THRESH      = 8'd96
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  dacLevel,
    input  logic        start,
    output logic        busy,
    output logic        valid,
    output logic        noSignal,
    output logic        overflow,
    output logic [31:0] edgeCount,
    output logic [31:0] spanCycles
`ifdef SQUARE_FREQ_METER_MINMAX_EN
    ,
    output logic [7:0]  levelMax,
    output logic [7:0]  levelMin
`endif
);
    localparam int unsigned CNT_W = 32;
    localparam logic [CNT_W-1:0] GATE_LAST    = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

    state_t           state_q, state_d;
    logic [7:0]       level_reg_q, level_reg_d;
    logic             sq_q, sq_d, sq_prev_q, sq_prev_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] gate_cnt_q, gate_cnt_d;
    logic [31:0]      edge_acc_q, edge_acc_d;
    logic [CNT_W-1:0] span_acc_q, span_acc_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d, valid_q, valid_d;
    logic             no_signal_q, no_signal_d, overflow_q, overflow_d;
    logic [31:0]      edge_count_q, edge_count_d, span_cycles_q, span_cycles_d;
    logic             rise_c;
`ifdef SQUARE_FREQ_METER_MINMAX_EN
    logic [7:0]       max_acc_q, max_acc_d, min_acc_q, min_acc_d;
    logic [7:0]       level_max_q, level_max_d, level_min_q, level_min_d;
`endif

    assign rise_c = sq_q & ~sq_prev_q;

    // Next-state and result computation; results load only on the transition into DONE.
    always_comb begin
        state_d       = state_q;
        level_reg_d   = dacLevel;
        sq_d          = sq_q;
        sq_prev_d     = sq_q;
        wait_cnt_d    = wait_cnt_q;
        gate_cnt_d    = gate_cnt_q;
        edge_acc_d    = edge_acc_q;
        span_acc_d    = span_acc_q;
        ovf_d         = ovf_q;
        busy_d        = busy_q;
        valid_d       = 1'b0;
        no_signal_d   = no_signal_q;
        overflow_d    = overflow_q;
        edge_count_d  = edge_count_q;
        span_cycles_d = span_cycles_q;
`ifdef SQUARE_FREQ_METER_MINMAX_EN
        max_acc_d     = max_acc_q;
        min_acc_d     = min_acc_q;
        level_max_d   = level_max_q;
        level_min_d   = level_min_q;
`endif

        if (level_reg_q >= HI_THRESH) begin
            sq_d = 1'b1;
        end else if (level_reg_q <= LO_THRESH) begin
            sq_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ARM;
                    busy_d     = 1'b1;
                    wait_cnt_d = '0;
                end
            end
            ARM: begin
                if (rise_c) begin
                    state_d    = MEASURE;
                    gate_cnt_d = '0;
                    edge_acc_d = 32'd1;
                    span_acc_d = '0;
                    ovf_d      = 1'b0;
`ifdef SQUARE_FREQ_METER_MINMAX_EN
                    max_acc_d  = 8'h00;
                    min_acc_d  = 8'hFF;
`endif
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    state_d       = DONE;
                    busy_d        = 1'b0;
                    valid_d       = 1'b1;
                    no_signal_d   = 1'b1;
                    overflow_d    = 1'b0;
                    edge_count_d  = '0;
                    span_cycles_d = '0;
`ifdef SQUARE_FREQ_METER_MINMAX_EN
                    level_max_d   = 8'h00;
                    level_min_d   = 8'h00;
`endif
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
            end
            MEASURE: begin
                gate_cnt_d = gate_cnt_q + 32'd1;
                if (rise_c) begin
                    if (edge_acc_q == '1) begin
                        ovf_d = 1'b1;
                    end else begin
                        edge_acc_d = edge_acc_q + 32'd1;
                    end
                    span_acc_d = gate_cnt_q + 32'd1;
                end
`ifdef SQUARE_FREQ_METER_MINMAX_EN
                if (level_reg_q > max_acc_q) max_acc_d = level_reg_q;
                if (level_reg_q < min_acc_q) min_acc_d = level_reg_q;
`endif
                // Last gate cycle: a rise here (offset GATE_CYCLES) is already folded in above.
                if (gate_cnt_q == GATE_LAST) begin
                    state_d       = DONE;
                    busy_d        = 1'b0;
                    valid_d       = 1'b1;
                    no_signal_d   = 1'b0;
                    overflow_d    = ovf_d;
                    edge_count_d  = edge_acc_d;
                    span_cycles_d = span_acc_d;
`ifdef SQUARE_FREQ_METER_MINMAX_EN
                    level_max_d   = max_acc_d;
                    level_min_d   = min_acc_d;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            level_reg_q   <= '0;
            sq_q          <= 1'b0;
            sq_prev_q     <= 1'b0;
            wait_cnt_q    <= '0;
            gate_cnt_q    <= '0;
            edge_acc_q    <= '0;
            span_acc_q    <= '0;
            ovf_q         <= 1'b0;
            busy_q        <= 1'b0;
            valid_q       <= 1'b0;
            no_signal_q   <= 1'b0;
            overflow_q    <= 1'b0;
            edge_count_q  <= '0;
            span_cycles_q <= '0;
`ifdef SQUARE_FREQ_METER_MINMAX_EN
            max_acc_q     <= '0;
            min_acc_q     <= '0;
            level_max_q   <= '0;
            level_min_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            level_reg_q   <= level_reg_d;
            sq_q          <= sq_d;
            sq_prev_q     <= sq_prev_d;
            wait_cnt_q    <= wait_cnt_d;
            gate_cnt_q    <= gate_cnt_d;
            edge_acc_q    <= edge_acc_d;
            span_acc_q    <= span_acc_d;
            ovf_q         <= ovf_d;
            busy_q        <= busy_d;
            valid_q       <= valid_d;
            no_signal_q   <= no_signal_d;
            overflow_q    <= overflow_d;
            edge_count_q  <= edge_count_d;
            span_cycles_q <= span_cycles_d;
`ifdef SQUARE_FREQ_METER_MINMAX_EN
            max_acc_q     <= max_acc_d;
            min_acc_q     <= min_acc_d;
            level_max_q   <= level_max_d;
            level_min_q   <= level_min_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign valid      = valid_q;
    assign noSignal   = no_signal_q;
    assign overflow   = overflow_q;
    assign edgeCount  = edge_count_q;
    assign spanCycles = span_cycles_q;
`ifdef SQUARE_FREQ_METER_MINMAX_EN
    assign levelMax   = level_max_q;
    assign levelMin   = level_min_q;
`endif

endmodule

// File: tb/tb_square_freq_meter.sv
// Bench for square_freq_meter: two instances (long and short gate) fed the same level stream,
// checked against a trace-based model that recomputes each measurement from the recorded levels.
`timescale 1ns/1ps
module tb_square_freq_meter;
    localparam int GATE_A = 100;
    localparam int GATE_B = 16;
    localparam int TMO    = 50;
    localparam int HIST   = 4096;
    localparam int RUN    = 220;
    localparam logic [7:0] HI = 8'd160;
    localparam logic [7:0] LO = 8'd96;
    localparam int M_SQ = 0, M_ZERO = 1, M_ALT = 2, M_CYC4 = 3, M_RAND = 4;

    logic        clk, rst, start;
    logic [7:0]  dacLevel;
    logic        busy_a, valid_a, nosig_a, ovf_a, busy_b, valid_b, nosig_b, ovf_b;
    logic [31:0] ec_a, sc_a, ec_b, sc_b;
`ifdef SQUARE_FREQ_METER_MINMAX_EN
    logic [7:0]  lmax_a, lmin_a, lmax_b, lmin_b;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int cyc;
    logic [7:0] lvl_hist [0:HIST-1];
    logic [7:0] sq_hi, sq_lo;
    longint res_ec_a, res_sc_a, res_ns_a, res_ec_b, res_sc_b, res_ns_b, res_mx_a, res_mn_a;

    square_freq_meter #(.GATE_CYCLES(GATE_A), .TIMEOUT_CYCLES(TMO)) dut_a (
        .clk(clk), .rst(rst), .dacLevel(dacLevel), .start(start),
        .busy(busy_a), .valid(valid_a), .noSignal(nosig_a), .overflow(ovf_a),
        .edgeCount(ec_a), .spanCycles(sc_a)
`ifdef SQUARE_FREQ_METER_MINMAX_EN
        , .levelMax(lmax_a), .levelMin(lmin_a)
`endif
    );

    square_freq_meter #(.GATE_CYCLES(GATE_B), .TIMEOUT_CYCLES(TMO)) dut_b (
        .clk(clk), .rst(rst), .dacLevel(dacLevel), .start(start),
        .busy(busy_b), .valid(valid_b), .noSignal(nosig_b), .overflow(ovf_b),
        .edgeCount(ec_b), .spanCycles(sc_b)
`ifdef SQUARE_FREQ_METER_MINMAX_EN
        , .levelMax(lmax_b), .levelMin(lmin_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge index since reset release and the level sampled at each edge.
    always @(posedge clk) begin
        if (rst) begin
            cyc <= 0;
        end else if (cyc < HIST - 1) begin
            cyc <= cyc + 1;
            lvl_hist[cyc + 1] <= dacLevel;
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [7:0] level_of(input int mode, input int period, input int k);
        case (mode)
            M_SQ:    return ((k % period) < (period / 2)) ? sq_hi : sq_lo;
            M_ZERO:  return 8'd0;
            M_ALT:   return (k % 2 == 1) ? 8'd136 : 8'd120;
            M_CYC4: begin
                case (k % 4)
                    0:       return 8'd10;
                    1:       return 8'd200;
                    2:       return 8'd250;
                    default: return 8'd30;
                endcase
            end
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // Slice the recorded trace with hysteresis; a sample whose slice rises at index j is seen
    // by the meter at edge j+2 (input register, then slicer register).
    task automatic predict(input int g, input int s, output int v_edge, output int ec,
                           output int sc, output int ns, output int mx, output int mn);
        bit h [0:HIST-1];
        int f, last;
        h[0] = 1'b0;
        for (int j = 1; j <= cyc; j++)
            h[j] = (lvl_hist[j] >= HI) ? 1'b1 : ((lvl_hist[j] <= LO) ? 1'b0 : h[j-1]);
        f = -1;
        for (int m = s + 1; m <= s + TMO && f < 0; m++)
            if (m >= 3 && h[m-2] && !h[m-3]) f = m;
        if (f < 0) begin
            v_edge = s + TMO; ec = 0; sc = 0; ns = 1; mx = 0; mn = 0;
        end else begin
            ec = 0; last = f; mx = 0; mn = 255;
            for (int m = f; m <= f + g; m++)
                if (h[m-2] && !h[m-3]) begin ec++; last = m; end
            for (int n = f; n < f + g; n++) begin
                if (int'(lvl_hist[n]) > mx) mx = int'(lvl_hist[n]);
                if (int'(lvl_hist[n]) < mn) mn = int'(lvl_hist[n]);
            end
            sc = last - f; v_edge = f + g; ns = 0;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy_a"}, longint'(busy_a), 0);
        check({tag, "_valid_a"}, longint'(valid_a), 0);
        check({tag, "_nosig_a"}, longint'(nosig_a), 0);
        check({tag, "_ovf_a"}, longint'(ovf_a), 0);
        check({tag, "_ec_a"}, longint'(ec_a), 0);
        check({tag, "_sc_a"}, longint'(sc_a), 0);
        check({tag, "_busy_b"}, longint'(busy_b), 0);
        check({tag, "_ec_b"}, longint'(ec_b), 0);
`ifdef SQUARE_FREQ_METER_MINMAX_EN
        check({tag, "_lmax_a"}, longint'(lmax_a), 0);
        check({tag, "_lmin_a"}, longint'(lmin_a), 0);
`endif
    endtask

    task automatic run_meas(input string tag, input int mode, input int period,
                            input bit do_rst, input bit dbl);
        int k = 0;
        int s_edge, na = 0, nb = 0, ea = -1, eb = -1;
        int v_e, ec, sc, ns, mx, mn;
        longint a_ec = 0, a_sc = 0, a_ns = 0, a_ov = 0, a_bz = 1, a_mx = 0, a_mn = 0;
        longint b_ec = 0, b_sc = 0, b_ns = 0, b_ov = 0, b_bz = 1;
        if (do_rst) begin
            @(negedge clk); rst = 1'b1; start = 1'b0;
            @(negedge clk); check_zero({tag, "_rst"});
            rst = 1'b0;
        end
        repeat (10 + $urandom_range(0, 7)) begin
            @(negedge clk); dacLevel = level_of(mode, period, k); k++;
        end
        @(negedge clk); dacLevel = level_of(mode, period, k); k++;
        start = 1'b1; s_edge = cyc + 1;
        for (int i = 0; i < RUN; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check({tag, "_busy_a"}, longint'(busy_a), 1);
                check({tag, "_busy_b"}, longint'(busy_b), 1);
            end
            if (valid_a) begin
                na++; ea = cyc; a_ec = longint'(ec_a); a_sc = longint'(sc_a);
                a_ns = longint'(nosig_a); a_ov = longint'(ovf_a); a_bz = longint'(busy_a);
`ifdef SQUARE_FREQ_METER_MINMAX_EN
                a_mx = longint'(lmax_a); a_mn = longint'(lmin_a);
`endif
            end
            if (valid_b) begin
                nb++; eb = cyc; b_ec = longint'(ec_b); b_sc = longint'(sc_b);
                b_ns = longint'(nosig_b); b_ov = longint'(ovf_b); b_bz = longint'(busy_b);
            end
            start = dbl && (i == 1);
            dacLevel = level_of(mode, period, k); k++;
        end
        predict(GATE_A, s_edge, v_e, ec, sc, ns, mx, mn);
        check({tag, "_nvalid_a"}, na, 1);
        check({tag, "_vedge_a"}, ea, v_e);
        check({tag, "_ec_a"}, a_ec, ec);
        check({tag, "_sc_a"}, a_sc, sc);
        check({tag, "_nosig_a"}, a_ns, ns);
        check({tag, "_ovf_a"}, a_ov, 0);
        check({tag, "_busyv_a"}, a_bz, 0);
`ifdef SQUARE_FREQ_METER_MINMAX_EN
        check({tag, "_lmax_a"}, a_mx, mx);
        check({tag, "_lmin_a"}, a_mn, mn);
`endif
        res_ec_a = a_ec; res_sc_a = a_sc; res_ns_a = a_ns; res_mx_a = a_mx; res_mn_a = a_mn;
        predict(GATE_B, s_edge, v_e, ec, sc, ns, mx, mn);
        check({tag, "_nvalid_b"}, nb, 1);
        check({tag, "_vedge_b"}, eb, v_e);
        check({tag, "_ec_b"}, b_ec, ec);
        check({tag, "_sc_b"}, b_sc, sc);
        check({tag, "_nosig_b"}, b_ns, ns);
        check({tag, "_ovf_b"}, b_ov, 0);
        check({tag, "_busyv_b"}, b_bz, 0);
        res_ec_b = b_ec; res_sc_b = b_sc; res_ns_b = b_ns;
    endtask

    // Start a measurement, abort it with a one-cycle reset, and confirm nothing completes.
    task automatic reset_mid();
        int k = 0;
        int na = 0, nb = 0;
        sq_hi = 8'd255; sq_lo = 8'd0;
        repeat (8) begin @(negedge clk); dacLevel = level_of(M_SQ, 8, k); k++; end
        @(negedge clk); dacLevel = level_of(M_SQ, 8, k); k++; start = 1'b1;
        repeat (20) begin @(negedge clk); start = 1'b0; dacLevel = level_of(M_SQ, 8, k); k++; end
        check("rm_busy_pre_a", longint'(busy_a), 1);
        rst = 1'b1;
        @(negedge clk);
        check_zero("rm");
        rst = 1'b0;
        repeat (150) begin
            @(negedge clk);
            if (valid_a) na++;
            if (valid_b) nb++;
            dacLevel = level_of(M_SQ, 8, k); k++;
        end
        check("rm_nvalid_a", na, 0);
        check("rm_nvalid_b", nb, 0);
        check("rm_busy_a", longint'(busy_a), 0);
        check("rm_ec_a", longint'(ec_a), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dacLevel = 8'd0; sq_hi = 8'd255; sq_lo = 8'd0;
        repeat (2) @(negedge clk);
        check_zero("por");
        rst = 1'b0;

        run_meas("sq8", M_SQ, 8, 1'b1, 1'b1);
        check("sq8_dir_ec_a", res_ec_a, 13);
        check("sq8_dir_sc_a", res_sc_a, 96);
        check("sq8_dir_ns_a", res_ns_a, 0);
        check("sq8_dir_ec_b", res_ec_b, 3);
        check("sq8_dir_sc_b", res_sc_b, 16);

        reset_mid();
        run_meas("post", M_SQ, 8, 1'b0, 1'b0);
        check("post_dir_ec_a", res_ec_a, 13);
        check("post_dir_sc_a", res_sc_a, 96);

        run_meas("zero", M_ZERO, 2, 1'b1, 1'b0);
        check("zero_dir_ns_a", res_ns_a, 1);
        check("zero_dir_ec_a", res_ec_a, 0);
        check("zero_dir_sc_b", res_sc_b, 0);

        run_meas("hyst", M_ALT, 2, 1'b1, 1'b0);
        check("hyst_dir_ns_a", res_ns_a, 1);
        check("hyst_dir_ns_b", res_ns_b, 1);

`ifdef SQUARE_FREQ_METER_MINMAX_EN
        run_meas("mm", M_CYC4, 4, 1'b1, 1'b0);
        check("mm_dir_max", res_mx_a, 250);
        check("mm_dir_min", res_mn_a, 10);
`endif

        for (int i = 0; i < 8; i++) begin
            sq_hi = 8'($urandom_range(120, 255));
            sq_lo = 8'($urandom_range(0, 140));
            run_meas($sformatf("rnd%0d", i), (i % 3 == 2) ? M_RAND : M_SQ,
                     $urandom_range(2, 30), 1'b1, i[0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
